// File: rtl/pcm_packet_writer_if.sv
`timescale 1ns/1ps
// Memory-side write channel of the PCM packet writer: one request per packet,
// completed by a single-cycle acknowledge from the memory controller.
interface pcm_packet_writer_if #(
  parameter int ADDR_WIDTH = 27,
  parameter int DATA_WIDTH = 64
);
  logic                  mem_ready_i;
  logic                  wr_req_o;
  logic [ADDR_WIDTH-1:0] wr_addr_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  wr_ack_i;

  modport master (
    input  mem_ready_i,
    input  wr_ack_i,
    output wr_req_o,
    output wr_addr_o,
    output wr_data_o
  );

  modport slave (
    output mem_ready_i,
    output wr_ack_i,
    input  wr_req_o,
    input  wr_addr_o,
    input  wr_data_o
  );
endinterface

// File: rtl/pcm_packet_writer.sv
`timescale 1ns/1ps
// Packs PCM samples into memory-width packets, buffers them in a small FIFO
// and writes each packet to consecutive byte addresses of a recording trace.
module pcm_packet_writer #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int PACKET_SAMPLES = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int ADDR_WIDTH     = 27
) (
  input  logic                    sys_clk,
  input  logic                    rst_n_i,
  input  logic                    enable_i,
  input  logic [SAMPLE_WIDTH-1:0] sample_i,
  input  logic                    sample_valid_i,
  input  logic                    flush_i,
  input  logic                    clear_i,
  pcm_packet_writer_if.master     mem,
  output logic [ADDR_WIDTH-1:0]   end_address_o,
  output logic                    overflow_o,
  output logic                    busy_o
);
  localparam int PKT_W  = SAMPLE_WIDTH * PACKET_SAMPLES;
  localparam int FILL_W = (PACKET_SAMPLES > 1) ? $clog2(PACKET_SAMPLES) : 1;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] PKT_BYTES = ADDR_WIDTH'(PKT_W / 8);
  localparam logic [FILL_W-1:0]     LAST_LANE = FILL_W'(PACKET_SAMPLES - 1);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  // Lanes at or beyond the used count hold stale bytes; force them to zero.
  function automatic logic [PKT_W-1:0] pad_lanes(input logic [PKT_W-1:0] pkt,
                                                 input logic [FILL_W:0]  used);
    logic [PKT_W-1:0] r;
    r = pkt;
    for (int i = 0; i < PACKET_SAMPLES; i++) begin
      if (i >= int'(used)) r[i*SAMPLE_WIDTH +: SAMPLE_WIDTH] = '0;
    end
    return r;
  endfunction

  state_t                  state_q, state_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic [FILL_W:0]         lanes_used;
  logic [PKT_W-1:0]        pack_q, pack_d;
  logic [PKT_W-1:0]        pkt_p0;
  logic                    vld_p0;
  logic [PKT_W-1:0]        fifo_mem [FIFO_DEPTH];
  logic [PTR_W:0]          wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [PKT_W-1:0]        wr_data_q;
  logic                    overflow_q;
  logic                    accept, emit, clear_ok;
  logic                    fifo_empty, fifo_full;
  logic                    push_ok, drop, pop, load_head;

  assign accept     = sample_valid_i & enable_i;
  assign lanes_used = {1'b0, fill_q} + {{FILL_W{1'b0}}, accept};
  assign emit       = (accept && (fill_q == LAST_LANE)) || (flush_i && (lanes_used != '0));
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign busy_o     = (state_q != IDLE) || !fifo_empty;
  assign clear_ok   = clear_i && !busy_o;
  // A pop in the same cycle frees the slot the incoming packet needs.
  assign push_ok    = vld_p0 && (!fifo_full || pop);
  assign drop       = vld_p0 && fifo_full && !pop;

  // Stage p0: sample packing; a completed or flushed packet is staged in pkt_p0
  always_comb begin
    pack_d = pack_q;
    if (accept) pack_d[int'(fill_q)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = sample_i;
  end

  always_comb begin
    fill_d = fill_q;
    if (clear_ok || emit) fill_d = '0;
    else if (accept)      fill_d = fill_q + FILL_W'(1);
  end

  always_ff @(posedge sys_clk) begin
    pack_q <= pack_d;
    if (emit) pkt_p0 <= pad_lanes(pack_d, lanes_used);
  end

  // Stage p1: FIFO write of the staged packet
  always_ff @(posedge sys_clk) begin
    if (push_ok) fifo_mem[wr_ptr_q[PTR_W-1:0]] <= pkt_p0;
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    load_head = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && mem.mem_ready_i) begin
          state_d   = ISSUE;
          load_head = 1'b1;
        end
      end
      ISSUE: begin
        // mem_ready_i is not looked at here: an issued request waits for its ack.
        if (mem.wr_ack_i) begin
          state_d = IDLE;
          pop     = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d = addr_q;
    if (clear_ok) addr_d = '0;
    else if (pop) addr_d = addr_q + PKT_BYTES;
  end

  always_ff @(posedge sys_clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      fill_q     <= '0;
      vld_p0     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
      wr_data_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      vld_p0  <= emit;
      addr_q  <= addr_d;
      if (push_ok)   wr_ptr_q <= wr_ptr_q + (PTR_W+1)'(1);
      if (pop)       rd_ptr_q <= rd_ptr_q + (PTR_W+1)'(1);
      if (clear_ok)  overflow_q <= 1'b0;
      else if (drop) overflow_q <= 1'b1;
      if (load_head) wr_data_q <= fifo_mem[rd_ptr_q[PTR_W-1:0]];
    end
  end

  assign mem.wr_req_o  = (state_q == ISSUE);
  assign mem.wr_addr_o = addr_q;
  assign mem.wr_data_o = wr_data_q;
  assign end_address_o = addr_q;
  assign overflow_o    = overflow_q;
endmodule

// File: tb/tb_pcm_packet_writer.sv
`timescale 1ns/1ps
// Bench for pcm_packet_writer: a packet model pushes expected requests into a
// queue that a request monitor pops and compares against the write channel.
module tb_pcm_packet_writer;
  localparam int AW = 27;

  logic          sys_clk = 1'b0;
  logic          rst_n_i, enable_i, sample_valid_i, flush_i, clear_i;
  logic [7:0]    sample_i;
  logic [AW-1:0] end_address_o;
  logic          overflow_o, busy_o;

  pcm_packet_writer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(64)) mem_bus ();

  pcm_packet_writer #(
    .SAMPLE_WIDTH(8), .PACKET_SAMPLES(8), .FIFO_DEPTH(4), .ADDR_WIDTH(AW)
  ) dut (
    .sys_clk        (sys_clk),
    .rst_n_i        (rst_n_i),
    .enable_i       (enable_i),
    .sample_i       (sample_i),
    .sample_valid_i (sample_valid_i),
    .flush_i        (flush_i),
    .clear_i        (clear_i),
    .mem            (mem_bus),
    .end_address_o  (end_address_o),
    .overflow_o     (overflow_o),
    .busy_o         (busy_o)
  );

  always #5 sys_clk = ~sys_clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Packet model and scoreboard
  logic [AW+63:0] exp_q[$];
  logic [7:0]     m_lane [8];
  int             m_fill = 0;
  logic [AW-1:0]  m_addr = '0;
  bit             m_drop = 1'b0;

  task automatic model_emit();
    logic [63:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) if (i < m_fill) d[i*8 +: 8] = m_lane[i];
    if (!m_drop) begin
      exp_q.push_back({m_addr, d});
      m_addr = m_addr + AW'(8);
    end
    m_fill = 0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge sys_clk); #1; end
  endtask

  task automatic drive(input logic [7:0] s, input bit v, input bit en, input bit f);
    sample_i = s; sample_valid_i = v; enable_i = en; flush_i = f;
    if (v && en) begin
      m_lane[m_fill] = s;
      m_fill++;
      if (m_fill == 8) model_emit();
    end
    if (f && m_fill > 0) model_emit();
    @(posedge sys_clk); #1;
    sample_valid_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic packet(input logic [7:0] base);
    for (int i = 0; i < 8; i++) drive(base + 8'(i), 1'b1, 1'b1, 1'b0);
  endtask

  task automatic pulse_clear();
    clear_i = 1'b1;
    @(posedge sys_clk); #1;
    clear_i = 1'b0;
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int i = 0; i < 400 && quiet < 3; i++) begin
      @(posedge sys_clk); #1;
      if (!busy_o && !mem_bus.wr_req_o) quiet++; else quiet = 0;
    end
    chk("idle_reached", 64'(quiet >= 3), 64'(1));
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic wait_req();
    int n = 0;
    while (!mem_bus.wr_req_o && n < 50) begin @(posedge sys_clk); #1; n++; end
    chk("req_within_bound", 64'(mem_bus.wr_req_o), 64'(1));
  endtask

  task automatic count_reqs(input string tag, input int n);
    int hits = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge sys_clk); #1;
      if (mem_bus.wr_req_o) hits++;
    end
    chk(tag, 64'(hits), 64'(0));
  endtask

  task automatic chk_reset_outputs(input string pfx);
    chk({pfx, "_wr_req"},   64'(mem_bus.wr_req_o),  64'(0));
    chk({pfx, "_wr_addr"},  64'(mem_bus.wr_addr_o), 64'(0));
    chk({pfx, "_wr_data"},  mem_bus.wr_data_o,      64'(0));
    chk({pfx, "_end_addr"}, 64'(end_address_o),     64'(0));
    chk({pfx, "_overflow"}, 64'(overflow_o),        64'(0));
    chk({pfx, "_busy"},     64'(busy_o),            64'(0));
  endtask

  // Memory controller acknowledge model
  int ack_delay = 3;
  bit ack_en    = 1'b1;
  bit stray_ack = 1'b0;
  int ack_cnt   = 0;
  initial begin
    mem_bus.wr_ack_i = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (mem_bus.wr_ack_i) begin
        mem_bus.wr_ack_i = 1'b0;
        ack_cnt = 0;
      end else if (stray_ack) begin
        mem_bus.wr_ack_i = 1'b1;
        stray_ack = 1'b0;
      end else if (mem_bus.wr_req_o && ack_en) begin
        ack_cnt++;
        if (ack_cnt >= ack_delay) mem_bus.wr_ack_i = 1'b1;
      end else begin
        ack_cnt = 0;
      end
    end
  end

  // Request monitor
  bit             req_seen = 1'b0;
  bit             hs_prev  = 1'b0;
  logic [AW-1:0]  held_addr;
  logic [63:0]    held_data;
  logic [AW+63:0] e;
  initial forever begin
    @(negedge sys_clk);
    if (!rst_n_i) begin
      req_seen = 1'b0;
      hs_prev  = 1'b0;
    end else begin
      if (hs_prev) chk("no_back_to_back_req", 64'(mem_bus.wr_req_o), 64'(0));
      if (mem_bus.wr_req_o && !req_seen) begin
        chk("req_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("req_addr", 64'(mem_bus.wr_addr_o), 64'(e[AW+63:64]));
          chk("req_data", mem_bus.wr_data_o, e[63:0]);
        end
        held_addr = mem_bus.wr_addr_o;
        held_data = mem_bus.wr_data_o;
      end else if (mem_bus.wr_req_o) begin
        chk("req_addr_stable", 64'(mem_bus.wr_addr_o), 64'(held_addr));
        chk("req_data_stable", mem_bus.wr_data_o, held_data);
      end
      req_seen = mem_bus.wr_req_o;
      hs_prev  = mem_bus.wr_req_o && mem_bus.wr_ack_i;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    rst_n_i = 1'b0; enable_i = 1'b1; sample_valid_i = 1'b0; flush_i = 1'b0;
    clear_i = 1'b0; sample_i = '0; mem_bus.mem_ready_i = 1'b1;
    cycles(3);
    chk_reset_outputs("reset");
    rst_n_i = 1'b1;
    cycles(2);

    // Eight samples form one packet; request rises two edges after the last one
    for (int i = 1; i <= 8; i++) drive(8'(i), 1'b1, 1'b1, 1'b0);
    cycles(1);
    chk("latency_edge1", 64'(mem_bus.wr_req_o), 64'(0));
    cycles(1);
    chk("latency_edge2", 64'(mem_bus.wr_req_o), 64'(1));
    wait_idle();
    chk("end_addr_first", 64'(end_address_o), 64'(8));

    // Partial packet flushed with zero padding; empty flush issues nothing
    drive(8'hA1, 1'b1, 1'b1, 1'b0);
    drive(8'hA2, 1'b1, 1'b1, 1'b0);
    drive(8'hA3, 1'b1, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    wait_idle();
    chk("end_addr_flush", 64'(end_address_o), 64'(16));
    drive(8'h00, 1'b0, 1'b1, 1'b1);
    count_reqs("no_req_empty_flush", 8);

    // Flush coinciding with a sample: completing sample, then partial sample
    for (int i = 0; i < 7; i++) drive(8'hC0 + 8'(i), 1'b1, 1'b1, 1'b0);
    drive(8'hC7, 1'b1, 1'b1, 1'b1);
    drive(8'h11, 1'b1, 1'b1, 1'b0);
    drive(8'h22, 1'b1, 1'b1, 1'b0);
    drive(8'h33, 1'b1, 1'b1, 1'b1);
    wait_idle();
    chk("end_addr_flush_sample", 64'(end_address_o), 64'(32));

    // Samples with enable low are dropped, fill count is kept
    drive(8'h51, 1'b1, 1'b1, 1'b0);
    drive(8'h52, 1'b1, 1'b0, 1'b0);
    cycles(3);
    for (int i = 3; i < 10; i++) drive(8'h50 + 8'(i), 1'b1, 1'b1, 1'b0);
    wait_idle();
    chk("end_addr_enable", 64'(end_address_o), 64'(40));
    stray_ack = 1'b1;
    cycles(4);
    chk("stray_ack_end_addr", 64'(end_address_o), 64'(40));
    chk("stray_ack_no_req", 64'(mem_bus.wr_req_o), 64'(0));

    pulse_clear();
    m_addr = '0;
    chk("clear_idle_end_addr", 64'(end_address_o), 64'(0));

    // Acks withheld: four packets buffered, fifth dropped
    ack_en = 1'b0;
    packet(8'h10); packet(8'h20); packet(8'h30); packet(8'h40);
    m_drop = 1'b1;
    packet(8'h50);
    m_drop = 1'b0;
    cycles(2);
    chk("overflow_set", 64'(overflow_o), 64'(1));
    chk("overflow_busy", 64'(busy_o), 64'(1));
    chk("overflow_addr_held", 64'(end_address_o), 64'(0));
    mem_bus.mem_ready_i = 1'b0;
    cycles(4);
    chk("req_held_ready_low", 64'(mem_bus.wr_req_o), 64'(1));
    pulse_clear();
    cycles(1);
    chk("clear_busy_overflow", 64'(overflow_o), 64'(1));
    chk("clear_busy_busy", 64'(busy_o), 64'(1));
    mem_bus.mem_ready_i = 1'b1;
    ack_en = 1'b1;
    wait_idle();
    chk("overflow_end_addr", 64'(end_address_o), 64'(32));
    chk("overflow_sticky", 64'(overflow_o), 64'(1));
    pulse_clear();
    m_addr = '0;
    chk("clear_end_addr", 64'(end_address_o), 64'(0));
    chk("clear_overflow", 64'(overflow_o), 64'(0));

    // Address counter preloaded near the top wraps to zero
    force dut.addr_q = 27'h7FFFFF8;
    cycles(1);
    release dut.addr_q;
    m_addr = 27'h7FFFFF8;
    cycles(1);
    chk("preload_end_addr", 64'(end_address_o), 64'h7FFFFF8);
    packet(8'h70);
    packet(8'h78);
    wait_idle();
    chk("wrap_end_addr", 64'(end_address_o), 64'(8));

    // Reset in the middle of an outstanding request
    ack_en = 1'b0;
    packet(8'hE0);
    wait_req();
    #3;
    rst_n_i = 1'b0;
    #1;
    chk_reset_outputs("mid_issue_reset");
    exp_q.delete();
    m_addr = '0;
    m_fill = 0;
    ack_en = 1'b1;
    @(posedge sys_clk);
    @(posedge sys_clk);
    #3;
    rst_n_i = 1'b1;
    count_reqs("no_req_after_reset", 10);
    chk("busy_after_reset", 64'(busy_o), 64'(0));
    packet(8'h90);
    wait_idle();
    chk("end_addr_after_reset", 64'(end_address_o), 64'(8));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
